uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter N, default 8: prescaler counter width.
REQ-002 Parameter PSCALER, default 1: sysclk cycles per oversample tick; legal range 1..2^N.
REQ-003 Parameter DIV, default 10: ticks per bit; legal minimum 2; one bit period = PSCALER*DIV sysclk cycles.
REQ-004 sysclk  input  1  clock; all logic on its rising edge.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 data_i  input  8  byte to transmit.
REQ-007 valid_i  input  1  data_i holds a byte to send.
REQ-008 ready_o  output  1  block can accept a byte this cycle.
REQ-009 parity_en_i  input  1  1 = append a parity bit.
REQ-010 parity_odd_i  input  1  1 = odd parity, 0 = even parity.
REQ-011 tx_o  output  1  serial line; idles high.
REQ-012 busy_o  output  1  frame in progress.
REQ-013 done_o  output  1  one-cycle pulse when a frame completes.

Function
REQ-014 The block SHALL use states IDLE, START, DATA, PARITY and STOP, with a safe encoding: any illegal state returns to IDLE.
REQ-015 ready_o SHALL be 1 only in IDLE; busy_o SHALL be the inverse of ready_o.
REQ-016 Accept SHALL occur on a rising edge where valid_i=1 and ready_o=1; data_i, parity_en_i and parity_odd_i SHALL be latched at accept.
REQ-017 Changes to data_i, parity_en_i or parity_odd_i after accept SHALL NOT affect the current frame.
REQ-018 valid_i in any state other than IDLE SHALL be ignored; no byte is queued.
REQ-019 In the cycle after accept, the state SHALL be START, tx_o SHALL be 0, and the prescaler and tick counters SHALL be 0.
REQ-020 Bit timing: the prescaler SHALL count 0..PSCALER-1.
REQ-021 The tick counter SHALL advance when the prescaler wraps and count 0..DIV-1.
REQ-022 A bit SHALL end when the prescaler is at PSCALER-1 and the tick counter is at DIV-1, so every bit lasts exactly PSCALER*DIV cycles.
REQ-023 After START, DATA SHALL send 8 bits LSB first, using a 3-bit index that counts 0..7.
REQ-024 DATA SHALL go to PARITY if parity is enabled, otherwise to STOP.
REQ-025 The PARITY bit SHALL be the XOR of the 8 latched data bits, XORed with parity_odd.
REQ-026 STOP SHALL drive tx_o=1 for one bit period and then go to IDLE.
REQ-027 done_o SHALL be 1 for exactly the first IDLE cycle after STOP; that cycle SHALL also be able to accept a byte.
REQ-028 Back-to-back frames: with valid_i held at 1, consecutive start-bit falling edges SHALL be PSCALER*DIV*F + 1 cycles apart, where F = 10 without parity and 11 with parity.
REQ-029 tx_o SHALL be driven from a register (no combinational glitches).
REQ-030 With PSCALER=1 the prescaler SHALL be treated as always wrapping.

Reset
REQ-031 While reset_n=0 at a rising edge, the next state SHALL be IDLE and all counters SHALL be 0.
REQ-032 Reset outputs: tx_o=1, ready_o=1, busy_o=0, done_o=0.
REQ-033 Reset mid-frame SHALL abort the frame: tx_o=1 the next cycle, and no done_o pulse.
REQ-034 Reset SHALL take priority over accept in the same cycle.

Verification
REQ-035 The bench SHALL cover: PSCALER=2, DIV=4, parity off, send 0xA5 -> tx_o = 0,1,0,1,0,0,1,0,1,1, each held 8 cycles; done_o pulses once, 81 cycles after accept.
REQ-036 The bench SHALL cover: same parameters, parity on and even, send 0xA5 -> parity bit 0 before stop; parity odd -> parity bit 1; frame 88 cycles.
REQ-037 The bench SHALL cover: valid_i held 1 with 0x00 then 0xFF -> second start edge 81 cycles after the first; second frame data bits all 1.
REQ-038 The bench SHALL cover: pulse valid_i with 0x3C while busy_o=1 -> ignored; the line carries only the original frame.
REQ-039 The bench SHALL cover: reset_n=0 during DATA bit 3 -> tx_o=1, ready_o=1 the next cycle, no done_o; a new send afterwards is correct.
REQ-040 The bench SHALL cover: PSCALER=1, DIV=2, send 0x01 -> bit period 2 cycles; tx_o = 0,1,0,0,0,0,0,0,0,1.

Source files
------------

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake and per-frame parity controls between a producer and uart_tx.
// Revision 1.0
`default_nettype none

interface uart_tx_if;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic       parity_en_i;
  logic       parity_odd_i;

  modport master (
    output data_i,
    output valid_i,
    output parity_en_i,
    output parity_odd_i,
    input  ready_o
  );

  modport slave (
    input  data_i,
    input  valid_i,
    input  parity_en_i,
    input  parity_odd_i,
    output ready_o
  );
endinterface

`default_nettype wire

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter, start/8 data LSB first/optional parity/stop, PSCALER*DIV sysclk per bit.
// Revision 1.0
`default_nettype none

module uart_tx #(
  parameter int N       = 8,
  parameter int PSCALER = 1,
  parameter int DIV     = 10
) (
  input  wire logic  sysclk,
  input  wire logic  reset_n,
  uart_tx_if.slave   bus,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [N-1:0]  C_PS_LAST  = N'(PSCALER - 1);
  localparam logic [TW-1:0] C_DIV_LAST = TW'(DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t        state_q;
  logic [N-1:0]  presc_q;
  logic [TW-1:0] tick_q;
  logic [2:0]    idx_q;
  logic [7:0]    data_q;
  logic          par_en_q;
  logic          par_odd_q;
  logic          tx_q;
  logic          ready_q;
  logic          done_q;

  logic          presc_wrap;
  logic          bit_end;
  logic [2:0]    idx_nxt;

  // A single-cycle prescaler never counts; every sysclk is a tick.
  generate
    if (PSCALER == 1) begin : g_presc_bypass
      assign presc_wrap = 1'b1;
    end else begin : g_presc_count
      assign presc_wrap = (presc_q == C_PS_LAST);
    end
  endgenerate

  assign bit_end = presc_wrap && (tick_q == C_DIV_LAST);
  assign idx_nxt = idx_q + 3'd1;

  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      tick_q    <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.valid_i) begin
            data_q    <= bus.data_i;
            par_en_q  <= bus.parity_en_i;
            par_odd_q <= bus.parity_odd_i;
            state_q   <= ST_START;
            tx_q      <= 1'b0;
            ready_q   <= 1'b0;
            presc_q   <= '0;
            tick_q    <= '0;
            idx_q     <= '0;
          end
        end

        ST_START, ST_DATA, ST_PARITY, ST_STOP: begin
          if (presc_wrap) begin
            presc_q <= '0;
            tick_q  <= bit_end ? '0 : tick_q + TW'(1);
          end else begin
            presc_q <= presc_q + N'(1);
          end

          if (bit_end) begin
            case (state_q)
              ST_START: begin
                state_q <= ST_DATA;
                idx_q   <= '0;
                tx_q    <= data_q[0];
              end
              ST_DATA: begin
                if (idx_q == 3'd7) begin
                  idx_q <= '0;
                  if (par_en_q) begin
                    state_q <= ST_PARITY;
                    tx_q    <= (^data_q) ^ par_odd_q;
                  end else begin
                    state_q <= ST_STOP;
                    tx_q    <= 1'b1;
                  end
                end else begin
                  idx_q <= idx_nxt;
                  tx_q  <= data_q[idx_nxt];
                end
              end
              ST_PARITY: begin
                state_q <= ST_STOP;
                tx_q    <= 1'b1;
              end
              ST_STOP: begin
                state_q <= ST_IDLE;
                tx_q    <= 1'b1;
                ready_q <= 1'b1;
                done_q  <= 1'b1;
              end
              default: begin
                state_q <= ST_IDLE;
              end
            endcase
          end
        end

        // Unreachable encodings recover to a clean idle line.
        default: begin
          state_q <= ST_IDLE;
          presc_q <= '0;
          tick_q  <= '0;
          idx_q   <= '0;
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready_o = ready_q;
  assign busy_o      = ~ready_q;
  assign tx_o        = tx_q;
  assign done_o      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized and directed frames on two uart_tx instances checked against a bit-list frame model.
// Revision 1.0
`default_nettype none

module tb_uart_tx;

  localparam int PS_A = 2;
  localparam int DIV_A = 4;
  localparam int T_A = PS_A * DIV_A;
  localparam int PS_B = 1;
  localparam int DIV_B = 2;
  localparam int T_B = PS_B * DIV_B;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic rst_a_n, rst_b_n;
  logic tx_a, busy_a, done_a;
  logic tx_b, busy_b, done_b;

  uart_tx_if if_a ();
  uart_tx_if if_b ();

  uart_tx #(.N(8), .PSCALER(PS_A), .DIV(DIV_A)) u_dut_a (
    .sysclk (sysclk),
    .reset_n(rst_a_n),
    .bus    (if_a.slave),
    .tx_o   (tx_a),
    .busy_o (busy_a),
    .done_o (done_a)
  );

  uart_tx #(.N(8), .PSCALER(PS_B), .DIV(DIV_B)) u_dut_b (
    .sysclk (sysclk),
    .reset_n(rst_b_n),
    .bus    (if_b.slave),
    .tx_o   (tx_b),
    .busy_o (busy_b),
    .done_o (done_b)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_a[$];
  int done_cnt_a = 0;
  logic prev_tx_a = 1'b1;
  bit exp_bits[$];

  always @(posedge sysclk) cyc <= cyc + 1;

  always @(negedge sysclk) begin
    if (prev_tx_a === 1'b1 && tx_a === 1'b0) fall_a.push_back(cyc);
    if (done_a === 1'b1) done_cnt_a++;
    prev_tx_a = tx_a;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Frame as a list of line levels, one entry per bit period.
  function automatic void model_frame(input logic [7:0] d, input bit pen, input bit podd);
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    if (pen) exp_bits.push_back((($countones(d) % 2) == 1) ? ~podd : podd);
    exp_bits.push_back(1'b1);
  endfunction

  function automatic logic get_tx(input bit sel);
    return sel ? tx_b : tx_a;
  endfunction
  function automatic logic get_busy(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction
  function automatic logic get_done(input bit sel);
    return sel ? done_b : done_a;
  endfunction
  function automatic logic get_ready(input bit sel);
    return sel ? if_b.ready_o : if_a.ready_o;
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [7:0] d, input logic pen, input logic podd);
    if (sel) begin
      if_b.valid_i = v; if_b.data_i = d; if_b.parity_en_i = pen; if_b.parity_odd_i = podd;
    end else begin
      if_a.valid_i = v; if_a.data_i = d; if_a.parity_en_i = pen; if_a.parity_odd_i = podd;
    end
  endtask

  // Returns at the negedge of the first busy cycle, with the inputs already scrambled.
  task automatic send(input bit sel, input logic [7:0] d, input bit pen, input bit podd);
    int w = 0;
    while (get_ready(sel) !== 1'b1 && w < 1000) begin
      @(negedge sysclk);
      w++;
    end
    check_eq("ready_before_send", 32'(get_ready(sel)), 32'd1);
    drive(sel, 1'b1, d, pen, podd);
    @(negedge sysclk);
    drive(sel, 1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
    model_frame(d, pen, podd);
  endtask

  // Walks the modelled frame cycle by cycle; ends at the negedge of the done cycle.
  task automatic check_frame(input bit sel, input int t, input int inject_at);
    int n = 0;
    foreach (exp_bits[i]) begin
      for (int k = 0; k < t; k++) begin
        check_eq($sformatf("tx_bit%0d", i), 32'(get_tx(sel)), 32'(exp_bits[i]));
        check_eq("busy_in_frame", 32'(get_busy(sel)), 32'd1);
        check_eq("done_in_frame", 32'(get_done(sel)), 32'd0);
        if (inject_at >= 0 && n == inject_at)
          drive(sel, 1'b1, 8'h3C, 1'($urandom), 1'($urandom));
        else if (inject_at >= 0 && n == inject_at + 1)
          drive(sel, 1'b0, 8'($urandom), 1'b0, 1'b0);
        n++;
        @(negedge sysclk);
      end
    end
    check_eq("done_pulse", 32'(get_done(sel)), 32'd1);
    check_eq("ready_at_done", 32'(get_ready(sel)), 32'd1);
    check_eq("tx_at_done", 32'(get_tx(sel)), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dc;
    logic [7:0] rd;
    bit rp, ro;
    int inj;

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge sysclk);

    check_eq("rst_tx_a", 32'(tx_a), 32'd1);
    check_eq("rst_ready_a", 32'(if_a.ready_o), 32'd1);
    check_eq("rst_busy_a", 32'(busy_a), 32'd0);
    check_eq("rst_done_a", 32'(done_a), 32'd0);
    check_eq("rst_tx_b", 32'(tx_b), 32'd1);
    check_eq("rst_ready_b", 32'(if_b.ready_o), 32'd1);

    // Reset wins over a simultaneous accept.
    drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    @(negedge sysclk);
    check_eq("rst_prio_tx", 32'(tx_a), 32'd1);
    check_eq("rst_prio_ready", 32'(if_a.ready_o), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    @(negedge sysclk);
    check_eq("idle_tx_a", 32'(tx_a), 32'd1);

    // 0xA5 without parity, then even and odd parity.
    send(1'b0, 8'hA5, 1'b0, 1'b0);
    check_frame(1'b0, T_A, -1);
    @(negedge sysclk);
    check_eq("done_one_cycle", 32'(done_a), 32'd0);
    send(1'b0, 8'hA5, 1'b1, 1'b0);
    check_frame(1'b0, T_A, -1);
    send(1'b0, 8'hA5, 1'b1, 1'b1);
    check_frame(1'b0, T_A, -1);

    // Back-to-back with valid held: 0x00 then 0xFF.
    @(negedge sysclk);
    drive(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    @(negedge sysclk);
    drive(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    model_frame(8'h00, 1'b0, 1'b0);
    check_frame(1'b0, T_A, -1);
    @(negedge sysclk);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    model_frame(8'hFF, 1'b0, 1'b0);
    check_frame(1'b0, T_A, -1);
    check_eq("b2b_falls", 32'(fall_a.size() >= 2), 32'd1);
    if (fall_a.size() >= 2)
      check_eq("b2b_spacing", 32'(fall_a[$] - fall_a[$-1]), 32'(T_A * 10 + 1));

    // valid pulse with 0x3C while busy must be dropped.
    send(1'b0, 8'h81, 1'b0, 1'b0);
    check_frame(1'b0, T_A, 12);
    for (int i = 0; i < 20; i++) begin
      @(negedge sysclk);
      check_eq("no_queued_tx", 32'(tx_a), 32'd1);
      check_eq("no_queued_ready", 32'(if_a.ready_o), 32'd1);
    end

    // Reset during DATA bit 3 aborts the frame.
    send(1'b0, 8'h52, 1'b0, 1'b0);
    repeat (T_A * 4 + 2) @(negedge sysclk);
    check_eq("abort_pre_tx", 32'(tx_a), 32'd0);
    dc = done_cnt_a;
    rst_a_n = 1'b0;
    @(negedge sysclk);
    check_eq("abort_tx", 32'(tx_a), 32'd1);
    check_eq("abort_ready", 32'(if_a.ready_o), 32'd1);
    check_eq("abort_busy", 32'(busy_a), 32'd0);
    rst_a_n = 1'b1;
    repeat (T_A * 10) @(negedge sysclk);
    check_eq("abort_no_done", 32'(done_cnt_a), 32'(dc));
    send(1'b0, 8'hA5, 1'b1, 1'b0);
    check_frame(1'b0, T_A, -1);

    // Minimum bit period instance.
    send(1'b1, 8'h01, 1'b0, 1'b0);
    check_frame(1'b1, T_B, -1);

    for (int i = 0; i < 12; i++) begin
      rd = 8'($urandom);
      rp = 1'($urandom);
      ro = 1'($urandom);
      inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 15)) : -1;
      send(1'(i % 2), rd, rp, ro);
      check_frame(1'(i % 2), (i % 2) ? T_B : T_A, inj);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
